dccm_sram_resp: RTL and testbench

//  Data-memory responder on the core's DCCM port: services the core's DCCM read/write strobes.

---
 rtl/dccm_sram_resp.sv | 161 ++++++++++++++++
 tb/tb_dccm_sram_resp.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dccm_sram_resp.sv
// DCCM data-memory responder: 1-cycle read SRAM with write-first forwarding, range/alignment
// error flags, a post-reset zero-clear sequence and a valid/ready preload port.
module dccm_sram_resp #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_dccm_wr_en,
    input  logic [31:0]              i_dccm_wr_addr,
    input  logic [31:0]              i_dccm_wr_data,
    input  logic                     i_dccm_rd_en,
    input  logic [31:0]              i_dccm_rd_addr,
    output logic [31:0]              o_dccm_rd_data,
    input  logic                     i_ld_valid,
    output logic                     o_ld_ready_c,
    input  logic [$clog2(DEPTH)-1:0] i_ld_idx,
    input  logic [31:0]              i_ld_data,
    output logic                     o_busy,
    output logic                     o_err_range,
    output logic                     o_err_align
);

    localparam int unsigned       IDX_W    = $clog2(DEPTH);
    localparam logic [32:0]       SPAN     = 33'(DEPTH) << 2;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_clr_ptr;
    logic [IDX_W-1:0]   w_clr_ptr_nxt;
    logic               r_busy;
    logic [31:0]        r_rd_data;
    logic               r_err_range;
    logic               r_err_align;
    logic [31:0]        r_mem [DEPTH];

    logic [32:0]        w_wr_off;
    logic [32:0]        w_rd_off;
    logic               w_wr_in_range;
    logic               w_rd_in_range;
    logic [IDX_W-1:0]   w_wr_idx;
    logic [IDX_W-1:0]   w_rd_idx;
    logic               w_ld_ready;
    logic               w_mem_we;
    logic [IDX_W-1:0]   w_mem_widx;
    logic [31:0]        w_mem_wdata;
    logic [31:0]        w_rd_val;
    logic               w_range_hit;
    logic               w_align_hit;

    // Address decode; BASE_ADDR is span-aligned so the word index is a plain slice of the address.
    assign w_wr_off      = {1'b0, i_dccm_wr_addr} - {1'b0, BASE_ADDR};
    assign w_rd_off      = {1'b0, i_dccm_rd_addr} - {1'b0, BASE_ADDR};
    assign w_wr_in_range = (w_wr_off < SPAN);
    assign w_rd_in_range = (w_rd_off < SPAN);
    assign w_wr_idx      = i_dccm_wr_addr[IDX_W+1:2];
    assign w_rd_idx      = i_dccm_rd_addr[IDX_W+1:2];

    assign w_range_hit = (i_dccm_wr_en & ~w_wr_in_range) | (i_dccm_rd_en & ~w_rd_in_range);
    assign w_align_hit = (i_dccm_wr_en & (i_dccm_wr_addr[1:0] != 2'b00))
                       | (i_dccm_rd_en & (i_dccm_rd_addr[1:0] != 2'b00));

    // State register and clear pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
            r_busy    <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
            r_busy    <= (w_state_nxt == S_CLEAR);
        end
    end

    // Next state and single write-port arbitration: clear, then core write, then preload.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        w_ld_ready    = 1'b0;
        w_mem_we      = 1'b0;
        w_mem_widx    = r_clr_ptr;
        w_mem_wdata   = 32'h0;
        case (r_state)
            S_CLEAR: begin
                w_mem_we      = 1'b1;
                w_mem_widx    = r_clr_ptr;
                w_mem_wdata   = 32'h0;
                w_clr_ptr_nxt = r_clr_ptr + IDX_W'(1);
                if (r_clr_ptr == LAST_IDX) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                w_ld_ready = ~i_dccm_wr_en;
                if (i_dccm_wr_en && w_wr_in_range) begin
                    w_mem_we    = 1'b1;
                    w_mem_widx  = w_wr_idx;
                    w_mem_wdata = i_dccm_wr_data;
                end else if (i_ld_valid && w_ld_ready) begin
                    w_mem_we    = 1'b1;
                    w_mem_widx  = i_ld_idx;
                    w_mem_wdata = i_ld_data;
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
            end
        endcase
    end

    // Write-first: a write landing on the read word this cycle is forwarded to the read.
    always_comb begin
        w_rd_val = r_mem[w_rd_idx];
        if (w_mem_we && (w_mem_widx == w_rd_idx)) begin
            w_rd_val = w_mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            r_mem[w_mem_widx] <= w_mem_wdata;
        end
    end

    // Read data register and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data   <= 32'h0;
            r_err_range <= 1'b0;
            r_err_align <= 1'b0;
        end else begin
            if (i_dccm_rd_en) begin
                if ((r_state == S_CLEAR) || !w_rd_in_range) begin
                    r_rd_data <= 32'h0;
                end else begin
                    r_rd_data <= w_rd_val;
                end
            end
            if (w_range_hit) begin
                r_err_range <= 1'b1;
            end
            if (w_align_hit) begin
                r_err_align <= 1'b1;
            end
        end
    end

    assign o_dccm_rd_data = r_rd_data;
    assign o_ld_ready_c   = w_ld_ready;
    assign o_busy         = r_busy;
    assign o_err_range    = r_err_range;
    assign o_err_align    = r_err_align;

endmodule

// File: tb/tb_dccm_sram_resp.sv
// Self-checking bench for dccm_sram_resp: directed scenarios plus randomized traffic
// compared against a word-array reference model.
module tb_dccm_sram_resp;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [31:0] BASE  = 32'h0000_4000;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [31:0]      wr_addr;
    logic [31:0]      wr_data;
    logic             rd_en;
    logic [31:0]      rd_addr;
    logic [31:0]      rd_data;
    logic             ld_valid;
    logic             ld_ready;
    logic [IDX_W-1:0] ld_idx;
    logic [31:0]      ld_data;
    logic             busy;
    logic             err_range;
    logic             err_align;

    int checks;
    int failures;

    logic [31:0] m_mem [DEPTH];
    int          m_clr;
    logic [31:0] m_rd;
    logic        m_er;
    logic        m_ea;

    dccm_sram_resp #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_dccm_wr_en   (wr_en),
        .i_dccm_wr_addr (wr_addr),
        .i_dccm_wr_data (wr_data),
        .i_dccm_rd_en   (rd_en),
        .i_dccm_rd_addr (rd_addr),
        .o_dccm_rd_data (rd_data),
        .i_ld_valid     (ld_valid),
        .o_ld_ready_c   (ld_ready),
        .i_ld_idx       (ld_idx),
        .i_ld_data      (ld_data),
        .o_busy         (busy),
        .o_err_range    (err_range),
        .o_err_align    (err_align)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit in_range(input logic [31:0] a);
        longint unsigned la;
        la = longint'(a);
        return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * longint'(DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] word_of(input logic [31:0] a);
        logic [31:0] w;
        w = (a - BASE) >> 2;
        return w[IDX_W-1:0];
    endfunction

    // One clock edge; the model applies the behavioural rules to the inputs held across it.
    task automatic tick();
        bit busy_now;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 32'h0;
            m_clr = DEPTH;
            m_rd  = 32'h0;
            m_er  = 1'b0;
            m_ea  = 1'b0;
        end else begin
            busy_now = (m_clr > 0);
            if (wr_en && !in_range(wr_addr)) m_er = 1'b1;
            if (rd_en && !in_range(rd_addr)) m_er = 1'b1;
            if (wr_en && wr_addr[1:0] != 2'b00) m_ea = 1'b1;
            if (rd_en && rd_addr[1:0] != 2'b00) m_ea = 1'b1;
            if (!busy_now) begin
                if (wr_en) begin
                    if (in_range(wr_addr)) m_mem[word_of(wr_addr)] = wr_data;
                end else if (ld_valid) begin
                    m_mem[ld_idx] = ld_data;
                end
            end
            if (rd_en) m_rd = (busy_now || !in_range(rd_addr)) ? 32'h0 : m_mem[word_of(rd_addr)];
            if (busy_now) m_clr = m_clr - 1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        ld_valid = 1'b0;
    endtask

    task automatic test_reset();
        int cnt;
        int bad;
        idle_inputs();
        rst      = 1'b1;
        ld_valid = 1'b1;
        ld_idx   = IDX_W'(3);
        ld_data  = 32'hFFFF_0003;
        tick();
        rst = 1'b0;
        checks++;
        if (rd_data !== 32'h0 || err_range !== 1'b0 || err_align !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: rd=%h er=%b ea=%b busy=%b expected rd=0 er=0 ea=0 busy=1",
                     rd_data, err_range, err_align, busy);
        end
        cnt = 0;
        bad = 0;
        while (busy === 1'b1 && cnt < int'(DEPTH) + 8) begin
            if (ld_ready !== 1'b0) bad++;
            cnt++;
            tick();
        end
        ld_valid = 1'b0;
        checks++;
        if (cnt != int'(DEPTH)) begin
            failures++;
            $display("FAIL clear_length: busy cycles=%0d expected %0d", cnt, DEPTH);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL ld_ready_in_clear: ready-high cycles=%0d expected 0", bad);
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            rd_en   = 1'b1;
            rd_addr = BASE + 32'(4 * i);
            tick();
            checks++;
            if (rd_data !== m_rd || rd_data !== 32'h0) begin
                failures++;
                $display("FAIL clear_readback[%0d]: got %h expected %h", i, rd_data, m_rd);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_addr = BASE + 32'h10; wr_data = 32'hDEAD_BEEF;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1; rd_addr = BASE + 32'h10;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL write_then_read: got %h expected deadbeef", rd_data);
        end
    endtask

    task automatic test_same_cycle();
        wr_en = 1'b1; wr_addr = BASE + 32'h20; wr_data = 32'h1234_5678;
        rd_en = 1'b1; rd_addr = BASE + 32'h20;
        tick();
        checks++;
        if (rd_data !== 32'h1234_5678) begin
            failures++;
            $display("FAIL write_first: got %h expected 12345678", rd_data);
        end
        rd_en = 1'b0; wr_data = 32'h0BAD_0BAD;
        tick();
        wr_en = 1'b0;
        tick();
        checks++;
        if (rd_data !== 32'h1234_5678) begin
            failures++;
            $display("FAIL rd_hold: got %h expected 12345678", rd_data);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_data !== 32'h0BAD_0BAD) begin
            failures++;
            $display("FAIL rewrite_read: got %h expected 0bad0bad", rd_data);
        end
    endtask

    task automatic test_preload();
        wr_en = 1'b1; wr_addr = BASE + 32'h40; wr_data = 32'h0000_4040;
        ld_valid = 1'b1; ld_idx = IDX_W'(5); ld_data = 32'hA5A5_A5A5;
        #1;
        checks++;
        if (ld_ready !== 1'b0) begin
            failures++;
            $display("FAIL ld_stall: ld_ready=%b expected 0", ld_ready);
        end
        tick();
        wr_en = 1'b0;
        #1;
        checks++;
        if (ld_ready !== 1'b1) begin
            failures++;
            $display("FAIL ld_accept: ld_ready=%b expected 1", ld_ready);
        end
        tick();
        ld_valid = 1'b0;
        rd_en = 1'b1; rd_addr = BASE + 32'h14;
        tick();
        checks++;
        if (rd_data !== 32'hA5A5_A5A5) begin
            failures++;
            $display("FAIL preload_read: got %h expected a5a5a5a5", rd_data);
        end
        rd_addr = BASE + 32'h40;
        tick();
        checks++;
        if (rd_data !== 32'h0000_4040) begin
            failures++;
            $display("FAIL core_wr_priority: got %h expected 00004040", rd_data);
        end
        ld_valid = 1'b1; ld_idx = IDX_W'(9); ld_data = 32'h5A5A_0009;
        rd_addr = BASE + 32'h24;
        tick();
        ld_valid = 1'b0; rd_en = 1'b0;
        checks++;
        if (rd_data !== 32'h5A5A_0009) begin
            failures++;
            $display("FAIL preload_forward: got %h expected 5a5a0009", rd_data);
        end
    endtask

    task automatic test_random();
        bit exp_ready;
        bit pend;
        pend = 1'b0;
        for (int n = 0; n < 600; n++) begin
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = BASE + 32'(4 * $urandom_range(0, 15));
            wr_data = $urandom;
            rd_en   = ($urandom_range(0, 1) == 1);
            rd_addr = BASE + 32'(4 * $urandom_range(0, 15));
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend    = 1'b1;
                ld_idx  = IDX_W'($urandom_range(0, 15));
                ld_data = $urandom;
            end
            ld_valid = pend;
            #1;
            exp_ready = (m_clr == 0) && !wr_en;
            checks++;
            if (ld_ready !== exp_ready) begin
                failures++;
                $display("FAIL rand_ld_ready[%0d]: got %b expected %b", n, ld_ready, exp_ready);
            end
            tick();
            if (ld_valid && exp_ready) pend = 1'b0;
            checks++;
            if (rd_data !== m_rd) begin
                failures++;
                $display("FAIL rand_rd[%0d]: got %h expected %h", n, rd_data, m_rd);
            end
        end
        idle_inputs();
        checks++;
        if (err_range !== m_er || err_align !== m_ea) begin
            failures++;
            $display("FAIL rand_flags: er=%b ea=%b expected er=%b ea=%b", err_range, err_align, m_er, m_ea);
        end
    endtask

    task automatic test_errors();
        wr_en = 1'b1; wr_addr = BASE + 32'(4 * (DEPTH - 1)); wr_data = 32'hC0DE_0001;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1; rd_addr = BASE + 32'(4 * (DEPTH - 1));
        tick();
        checks++;
        if (rd_data !== 32'hC0DE_0001 || err_range !== 1'b0) begin
            failures++;
            $display("FAIL last_word: rd=%h er=%b expected rd=c0de0001 er=0", rd_data, err_range);
        end
        rd_addr = BASE + 32'(4 * DEPTH);
        tick();
        checks++;
        if (rd_data !== 32'h0 || err_range !== 1'b1 || err_align !== 1'b0) begin
            failures++;
            $display("FAIL above_range: rd=%h er=%b ea=%b expected rd=0 er=1 ea=0", rd_data, err_range, err_align);
        end
        rd_addr = BASE + 32'h14;
        tick();
        rd_addr = BASE - 32'h4;
        tick();
        checks++;
        if (rd_data !== 32'h0) begin
            failures++;
            $display("FAIL below_range: rd=%h expected 0", rd_data);
        end
        rd_en = 1'b0;
        wr_en = 1'b1; wr_addr = BASE + 32'h3; wr_data = 32'h0BAD_F00D;
        tick();
        wr_en = 1'b0;
        checks++;
        if (err_align !== 1'b1) begin
            failures++;
            $display("FAIL align_flag: ea=%b expected 1", err_align);
        end
        rd_en = 1'b1; rd_addr = BASE;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_data !== 32'h0BAD_F00D || rd_data !== m_rd) begin
            failures++;
            $display("FAIL misaligned_write: got %h expected 0badf00d", rd_data);
        end
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        rd_en = 1'b1; rd_addr = BASE + 32'(4 * DEPTH);
        wr_en = 1'b1; wr_addr = BASE + 32'h8; wr_data = 32'h0000_0077;
        tick();
        idle_inputs();
        checks++;
        if (rd_data !== 32'h0 || err_range !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL clear_err_update: rd=%h er=%b busy=%b expected rd=0 er=1 busy=1", rd_data, err_range, busy);
        end
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (err_range !== 1'b0 || err_align !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_clear_reset: er=%b ea=%b busy=%b expected 0 0 1", err_range, err_align, busy);
        end
        cnt = 0;
        while (busy === 1'b1 && cnt < int'(DEPTH) + 8) begin
            cnt++;
            tick();
        end
        checks++;
        if (cnt != int'(DEPTH)) begin
            failures++;
            $display("FAIL reclear_length: busy cycles=%0d expected %0d", cnt, DEPTH);
        end
        rd_en = 1'b1; rd_addr = BASE + 32'h8;
        tick();
        rd_addr = BASE + 32'h10;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_data !== 32'h0 || rd_data !== m_rd) begin
            failures++;
            $display("FAIL recleared_word: got %h expected 0", rd_data);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = 32'h0;
        wr_data  = 32'h0;
        rd_en    = 1'b0;
        rd_addr  = 32'h0;
        ld_valid = 1'b0;
        ld_idx   = '0;
        ld_data  = 32'h0;
        m_clr    = DEPTH;
        m_rd     = 32'h0;
        m_er     = 1'b0;
        m_ea     = 1'b0;
        test_reset();
        test_write_read();
        test_same_cycle();
        test_preload();
        test_random();
        test_errors();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
